bus_slave_mem: RTL and testbench

//  Byte-addressed memory slave on the unidirectional bus, one instance per slave_en bit.

---
 rtl/bus_slave_mem_if.sv | 22 ++
 rtl/bus_slave_mem.sv | 217 +++++++++++++++++++++
 tb/tb_bus_slave_mem.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_if.sv
// Master-to-slave bus bundle for one memory slave. The master side drives the
// decoded select, address, write data and control. The slave side returns the
// {ready, rdata} response, busy and the illegal-burst error pulse.
interface bus_slave_mem_if;
  logic        sel;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [8:0]  control;
  logic [32:0] rdata_ready;
  logic        busy;
  logic        err;

  modport master (
    output sel, address, wdata, control,
    input  rdata_ready, busy, err
  );

  modport slave (
    input  sel, address, wdata, control,
    output rdata_ready, busy, err
  );
endinterface

// File: rtl/bus_slave_mem.sv
// Byte-addressed memory slave. It executes single and burst transfers of
// B/HW/W/DW elements. Every write beat is acknowledged one cycle after it is
// accepted. Reads start streaming data WAIT_STATES+1 cycles after the start beat.
// All outputs are registered, so no input reaches an output combinationally.
module bus_slave_mem #(
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           reset,
  bus_slave_mem_if.slave bus
);
  localparam int MEM_BYTES = 2 ** MEM_ADDR_W;
  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_HW = 2'b01;
  localparam logic [1:0] SZ_DW = 2'b11;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

  // Address advance per beat. A DW element moves as two 32-bit beats.
  function automatic addr_t step_of(input logic [1:0] size);
    case (size)
      SZ_B:    step_of = addr_t'(1);
      SZ_HW:   step_of = addr_t'(2);
      default: step_of = addr_t'(4);
    endcase
  endfunction

  // Transfer state
  state_t      state_reg, state_next;
  addr_t       addr_reg, addr_next;
  logic [1:0]  size_reg, size_next;
  logic [5:0]  beats_left_reg, beats_left_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic [32:0] rdata_ready_reg, rdata_ready_next;
  logic        err_reg, err_next;

  // Byte storage. It is never cleared by reset.
  logic [7:0] mem [MEM_BYTES];

  // Request decode
  logic       accepted;
  logic       start_beat;
  logic       req_write;
  logic       burst_bad;
  logic [1:0] req_size;
  logic [3:0] req_code;
  logic [5:0] req_beats;
  addr_t      req_addr;
  logic       unused_addr_bits;

  assign accepted         = bus.sel & bus.control[8];
  assign start_beat       = accepted & bus.control[7];
  assign req_write        = bus.control[0];
  assign req_size         = bus.control[2:1];
  assign req_code         = bus.control[6:3];
  assign burst_bad        = (req_code > 4'd4);
  assign req_addr         = bus.address[MEM_ADDR_W-1:0];
  assign unused_addr_bits = ^bus.address[31:MEM_ADDR_W];

  // Beat count of the requested burst: illegal codes collapse to one beat, DW doubles it
  always_comb begin
    req_beats = burst_bad ? 6'd1 : (6'd1 << req_code[2:0]);
    if (req_size == SZ_DW) begin
      req_beats = req_beats << 1;
    end
  end

  // Lane addressing: a start beat uses the bus address, later beats the running pointer
  addr_t                      xfer_base;
  logic [1:0]                 xfer_size;
  logic                       wr_en;
  logic [3:0]                 wr_mask;
  logic [3:0]                 lane_we;
  logic [3:0][MEM_ADDR_W-1:0] lane_addr;
  logic [3:0][7:0]            rd_lane_data;
  logic [31:0]                rd_word;

  // Select the base address and size of the beat being handled this cycle
  always_comb begin
    xfer_base = start_beat ? req_addr : addr_reg;
    xfer_size = start_beat ? req_size : size_reg;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // Each lane wraps independently, so a beat can straddle the top of memory
      assign lane_addr[gi]    = xfer_base + addr_t'(gi);
      assign rd_lane_data[gi] = mem[lane_addr[gi]];
    end
  endgenerate

  // Lane enables per element size. No write happens while reset is held.
  always_comb begin
    case (xfer_size)
      SZ_B:    wr_mask = 4'b0001;
      SZ_HW:   wr_mask = 4'b0011;
      default: wr_mask = 4'b1111;
    endcase
    lane_we = {4{wr_en & reset}} & wr_mask;
  end

  // Read data zero-extended to the element size
  always_comb begin
    case (xfer_size)
      SZ_B:    rd_word = {24'd0, rd_lane_data[0]};
      SZ_HW:   rd_word = {16'd0, rd_lane_data[1], rd_lane_data[0]};
      default: rd_word = rd_lane_data;
    endcase
  end

  // Byte-lane memory writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[lane_addr[i]] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic. A start beat always opens a new
  // transfer and silently drops whatever was in progress.
  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    size_next        = size_reg;
    beats_left_next  = beats_left_reg;
    wait_cnt_next    = wait_cnt_reg;
    rdata_ready_next = '0;
    err_next         = 1'b0;
    wr_en            = 1'b0;

    if (start_beat) begin
      err_next  = burst_bad;
      size_next = req_size;
      if (req_write) begin
        wr_en            = 1'b1;
        rdata_ready_next = {1'b1, 32'd0};
        addr_next        = req_addr + step_of(req_size);
        beats_left_next  = req_beats - 6'd1;
        state_next       = (req_beats == 6'd1) ? IDLE : WR_BURST;
      end else if (WAIT_STATES == 0) begin
        rdata_ready_next = {1'b1, rd_word};
        addr_next        = req_addr + step_of(req_size);
        beats_left_next  = req_beats - 6'd1;
        state_next       = RD_DATA;
      end else begin
        addr_next        = req_addr;
        beats_left_next  = req_beats;
        wait_cnt_next    = 3'(WAIT_STATES - 1);
        state_next       = RD_WAIT;
      end
    end else begin
      case (state_reg)
        WR_BURST: begin
          // Only accepted beats advance the burst; anything else is a stall
          if (accepted) begin
            wr_en            = 1'b1;
            rdata_ready_next = {1'b1, 32'd0};
            addr_next        = addr_reg + step_of(size_reg);
            beats_left_next  = beats_left_reg - 6'd1;
            if (beats_left_reg == 6'd1) begin
              state_next = IDLE;
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt_reg == 3'd0) begin
            rdata_ready_next = {1'b1, rd_word};
            addr_next        = addr_reg + step_of(size_reg);
            beats_left_next  = beats_left_reg - 6'd1;
            state_next       = RD_DATA;
          end else begin
            wait_cnt_next = wait_cnt_reg - 3'd1;
          end
        end
        RD_DATA: begin
          // beats_left counts beats not yet loaded into the output register
          if (beats_left_reg == 6'd0) begin
            state_next = IDLE;
          end else begin
            rdata_ready_next = {1'b1, rd_word};
            addr_next        = addr_reg + step_of(size_reg);
            beats_left_next  = beats_left_reg - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      size_reg        <= '0;
      beats_left_reg  <= '0;
      wait_cnt_reg    <= '0;
      rdata_ready_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      size_reg        <= size_next;
      beats_left_reg  <= beats_left_next;
      wait_cnt_reg    <= wait_cnt_next;
      rdata_ready_reg <= rdata_ready_next;
      err_reg         <= err_next;
    end
  end

  assign bus.rdata_ready = rdata_ready_reg;
  assign bus.err         = err_reg;
  assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem. The driver pushes the expected ready
// beats, each with its due cycle, and the expected error pulses. A negedge
// monitor pops and compares them against what the slave presents.
`timescale 1ns/1ps
module tb_bus_slave_mem;
  localparam int W  = 1;
  localparam int AW = 10;
  localparam int MB = 1 << AW;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bus_slave_mem_if bus ();

  bus_slave_mem #(.MEM_ADDR_W(AW), .WAIT_STATES(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues and the reference memory
  exp_t        exp_q[$];
  int          err_q[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [7:0]  mm [MB];

  // Driver-owned request to check busy; the monitor compares it
  int chk_req = 0;
  bit chk_busy_exp = 1'b0;
  bit done = 1'b0;

  // Monitor-owned counters
  int checks = 0;
  int errors = 0;
  int chk_seen = 0;

  function automatic int nbeats(input int code, input int sz);
    int n;
    n = (code > 4) ? 1 : (1 << code);
    return (sz == 3) ? 2 * n : n;
  endfunction

  function automatic int step(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic void model_write(input int a, input int sz, input logic [31:0] d);
    for (int i = 0; i < step(sz); i++) mm[(a + i) % MB] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_read(input int a, input int sz);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < step(sz); i++) r[8*i +: 8] = mm[(a + i) % MB];
    return r;
  endfunction

  function automatic logic [31:0] bus_addr(input int a);
    logic [31:0] r;
    r = $urandom;
    r[AW-1:0] = AW'(a);
    return r;
  endfunction

  task automatic drive(input bit s, input bit v, input bit st, input bit wr,
                       input int sz, input int code, input logic [31:0] a,
                       input logic [31:0] d);
    bus.sel     = s;
    bus.address = a;
    bus.wdata   = d;
    bus.control = {v, st, 4'(code), 2'(sz), wr};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic req_busy(input bit e);
    chk_busy_exp = e;
    chk_req++;
  endtask

  task automatic settle();
    req_busy(0);
    idle(1);
  endtask

  // A start beat aborts anything still pending in the slave
  task automatic start_common(input int code);
    while (exp_q.size() != 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    if (code > 4) err_q.push_back(cyc + 1);
  endtask

  // mode: 0 back-to-back, 1 stall every other cycle, 2 random stalls
  task automatic do_write(input int a, input int sz, input int code, input int mode);
    int nb;
    int cur;
    bit gap;
    bit go;
    logic [31:0] d;
    nb  = nbeats(code, sz);
    cur = a;
    gap = 1'b0;
    $display("wr addr=%03h size=%0d code=%0d beats=%0d mode=%0d", a, sz, code, nb, mode);
    for (int b = 0; b < nb; ) begin
      go = (b == 0) || (mode == 0) || (mode == 1 ? gap : ($urandom_range(0, 1) == 1));
      if (go) begin
        d = (wq.size() != 0) ? wq.pop_front() : $urandom;
        if (b == 0) start_common(code);
        model_write(cur, sz, d);
        exp_q.push_back('{cyc + 1, 32'd0});
        drive(1, 1, b == 0, 1, sz, code, bus_addr(cur), d);
        cur = (cur + step(sz)) % MB;
        b++;
        gap = 1'b0;
      end else begin
        // Not accepted: either sel or valid low; a stray start bit must be ignored
        req_busy(1);
        if ($urandom_range(0, 1) == 1)
          drive(0, 1, $urandom_range(0, 1), 1, sz, 0, bus_addr(cur), $urandom);
        else
          drive(1, 0, $urandom_range(0, 1), 1, sz, 0, bus_addr(cur), $urandom);
        gap = 1'b1;
      end
    end
    req_busy(0);
    idle(1);
  endtask

  task automatic do_read(input int a, input int sz, input int code, input bit hold);
    int nb;
    int cur;
    logic [31:0] e;
    nb  = nbeats(code, sz);
    cur = a;
    $display("rd addr=%03h size=%0d code=%0d beats=%0d", a, sz, code, nb);
    start_common(code);
    for (int b = 0; b < nb; b++) begin
      e = (rq.size() != 0) ? rq.pop_front() : model_read(cur, sz);
      exp_q.push_back('{cyc + 1 + W + b, e});
      cur = (cur + step(sz)) % MB;
    end
    drive(1, 1, 1, 0, sz, code, bus_addr(a), $urandom);
    if (hold) idle(nb + W + 2);
  endtask

  // Monitor: compares every cycle on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (bus.rdata_ready[32]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ready_unexpected cyc=%0d got=%08h required=none", cyc, bus.rdata_ready[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.data !== bus.rdata_ready[31:0]) begin
          errors++;
          $display("FAIL ready_beat cyc=%0d got=%08h required=%08h at cyc %0d",
                   cyc, bus.rdata_ready[31:0], e.data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (bus.rdata_ready[31:0] !== 32'd0) begin
        errors++;
        $display("FAIL rdata_idle cyc=%0d got=%08h required=00000000", cyc, bus.rdata_ready[31:0]);
      end
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL ready_missing cyc=%0d got=none required=%08h at cyc %0d",
                 cyc, exp_q[0].data, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    if (bus.err === 1'b1) begin
      checks++;
      if (err_q.size() != 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
      end else begin
        errors++;
        $display("FAIL err_pulse cyc=%0d got=1 required=0", cyc);
      end
    end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL err_missing cyc=%0d got=0 required=1", cyc);
      void'(err_q.pop_front());
    end
    if (chk_req != chk_seen) begin
      chk_seen = chk_req;
      checks++;
      if (bus.busy !== chk_busy_exp) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%0b required=%0b", cyc, bus.busy, chk_busy_exp);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got=%0d beats %0d errs required=0", exp_q.size(), err_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int due;
    rst_n       = 1'b0;
    bus.sel     = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    bus.control = '0;
    repeat (3) @(posedge clk);
    #1;
    req_busy(0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Fill the whole memory so any later read has a known value
    for (int base = 0; base < MB; base += 64) do_write(base, 2, 4, 0);

    // Byte burst, then halfword read-back
    wq = '{32'hFFFFFF45, 32'hFFFFFF99};
    do_write(0, 0, 1, 0);
    rq = '{32'h00009945};
    do_read(0, 1, 0, 1);
    settle();

    // Halfword burst of 4, word burst-2 read across the elements
    wq = '{32'hDEAD2233, 32'hBEEF4455, 32'hCAFE6677, 32'h12349988};
    do_write(6, 1, 2, 0);
    rq = '{32'h44552233, 32'h99886677};
    do_read(6, 2, 1, 1);
    settle();

    // Doubleword: two beats each way
    wq = '{32'h11111111, 32'h22222222};
    do_write(20, 3, 0, 0);
    rq = '{32'h11111111, 32'h22222222};
    do_read(20, 3, 0, 1);
    settle();

    // Word burst across the top of memory
    wq = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
    do_write(MB - 4, 2, 2, 0);
    rq = '{32'h0000000B};
    do_read(0, 2, 0, 1);
    settle();

    // Word burst-8 with sel toggling, then verify contents
    do_write(12'h080, 2, 3, 1);
    do_read(12'h080, 2, 3, 1);
    settle();

    // Illegal burst code: err pulse and a single beat; a trailing beat is ignored
    do_write(12'h0C0, 2, 7, 0);
    drive(1, 1, 0, 1, 2, 0, bus_addr(12'h0C4), 32'h5A5A5A5A);
    settle();
    do_read(12'h0C0, 2, 1, 1);
    settle();
    do_read(12'h0D0, 1, 6, 1);
    settle();

    // Reset in the middle of a 16-beat read, on beat 5
    do_read(12'h100, 2, 4, 0);
    due = cyc + W + 4;
    while (cyc < due) begin
      req_busy(1);
      idle(1);
    end
    rst_n = 1'b0;
    while (exp_q.size() != 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    req_busy(0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    do_read(12'h100, 2, 4, 1);
    settle();

    // Write burst aborted after two beats by a new read start
    $display("wr-abort addr=200");
    start_common(0);
    k = $urandom;
    model_write(12'h200, 2, k);
    exp_q.push_back('{cyc + 1, 32'd0});
    drive(1, 1, 1, 1, 2, 2, bus_addr(12'h200), k);
    k = $urandom;
    model_write(12'h204, 2, k);
    exp_q.push_back('{cyc + 1, 32'd0});
    drive(1, 1, 0, 1, 2, 2, bus_addr(12'h204), k);
    do_read(12'h200, 2, 2, 1);
    settle();

    // Read burst aborted on its third beat by a new read start
    do_read(12'h300, 2, 3, 0);
    due = cyc + W + 2;
    while (cyc < due) idle(1);
    do_read(12'h340, 1, 1, 1);
    settle();

    // Randomised traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      int a;
      int sz;
      int code;
      a    = $urandom_range(0, MB - 1);
      sz   = $urandom_range(0, 3);
      code = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) do_write(a, sz, code, $urandom_range(0, 2));
      else do_read(a, sz, code, 1);
      settle();
    end

    idle(2);
    done = 1'b1;
  end
endmodule
